// File: rtl/calc_tx_pkg.sv
// Shared types and constants for the calculator serial transmitter.
package calc_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

    // Bit period (in clock cycles) loaded into the divisor on reset.
    localparam int TX_DIV_RESET = 2;

    // Width of a counter that indexes DATA_W payload bits.
    function automatic int bit_cnt_w(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: holds the programmable period T and a 0..T-1 cycle counter,
// flagging the last cycle of every bit period while the transmitter is busy.
module tx_bit_timer
    import calc_tx_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             bit_tick
);

    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt;

    assign bit_tick = run && (cnt == period - DIV_W'(1));

    // Period register; a zero divisor is promoted to one cycle per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            period <= DIV_W'(TX_DIV_RESET);
        end else if (load) begin
            period <= (div_cfg == '0) ? DIV_W'(1) : div_cfg;
        end
    end

    // Cycle counter: restarts on a new frame, wraps at each bit boundary.
    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            cnt <= '0;
        end else if (bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx_frame.sv
// Serial frame transmitter: accepts a word over valid/ready, shifts it out on
// Dout at a programmable bit period, and pulses TxDone when the frame ends.
// Optional feature macro: TX_PARITY_EN appends one even-parity bit per frame.
module serial_tx_frame
    import calc_tx_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_W     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataValid,
    output logic              DataReady,
    input  logic [DIV_W-1:0]  DivCfg,
    input  logic              ConfigDiv,
    output logic              Dout,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int BW = bit_cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state, state_nxt;
    logic              dout_nxt, busy_nxt, done_nxt, ready_nxt;
    logic              accept, advance, bit_tick, div_load;
    logic [DATA_W-1:0] rev, ordered;
    logic [DATA_W-2:0] shreg;
    logic [BW-1:0]     bit_cnt;
`ifdef TX_PARITY_EN
    logic              par_acc;
`endif

    assign div_load = ConfigDiv && (state == IDLE);

    tx_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .clear    (accept),
        .run      (TxBusy),
        .load     (div_load),
        .div_cfg  (DivCfg),
        .bit_tick (bit_tick)
    );

    // Arrange the payload so the first bit to send is always the top bit.
    always_comb begin
        rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rev[i] = DataIn[DATA_W-1-i];
        end
        ordered = (MSB_FIRST != 0) ? DataIn : rev;
    end

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_nxt = state;
        dout_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (DataValid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                    dout_nxt  = ordered[DATA_W-1];
                    busy_nxt  = 1'b1;
                    ready_nxt = 1'b0;
                end
            end
            SHIFT: begin
                busy_nxt = 1'b1;
                dout_nxt = Dout;
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
                        state_nxt = PARITY;
                        dout_nxt  = par_acc ^ Dout;
`else
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        dout_nxt  = 1'b0;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        advance  = 1'b1;
                        dout_nxt = shreg[DATA_W-2];
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                busy_nxt = 1'b1;
                dout_nxt = Dout;
                if (bit_tick) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    dout_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Dout      <= 1'b0;
            TxBusy    <= 1'b0;
            TxDone    <= 1'b0;
            DataReady <= 1'b1;
        end else begin
            state     <= state_nxt;
            Dout      <= dout_nxt;
            TxBusy    <= busy_nxt;
            TxDone    <= done_nxt;
            DataReady <= ready_nxt;
        end
    end

    // Shift register holds the bits not yet on Dout; bit counter tracks position.
    always_ff @(posedge Clk) begin
        if (accept) begin
            shreg   <= ordered[DATA_W-2:0];
            bit_cnt <= '0;
        end else if (advance) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

`ifdef TX_PARITY_EN
    // Running XOR of every payload bit already placed on Dout.
    always_ff @(posedge Clk) begin
        if (accept) begin
            par_acc <= 1'b0;
        end else if ((state == SHIFT) && bit_tick) begin
            par_acc <= par_acc ^ Dout;
        end
    end
`endif

endmodule
